// File: rtl/i2c_xfer_seq_pkg.sv
// Shared types for the I2C register-transfer sequencer.
// Holds the FSM state encoding, the read/write direction constants and the
// byte-controller command bundle.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, REG, WWAIT, WDATA, RADDR, RDATA, STOP, FIN
  } state_t;

  // Direction bit, also used as the LSB of the address byte on the wire
  localparam logic WR = 1'b0;
  localparam logic RD = 1'b1;

  typedef struct packed {
    logic start;
    logic stop;
    logic read;
    logic write;
    logic ack_in;
  } cmd_t;

endpackage

// File: rtl/i2c_xfer_seq_if.sv
// Bundle of request, write-data, read-data, byte-controller and status signals.
// master = the sequencer, slave = the surrounding logic / byte controller.
// LEN_W must match the sequencer instance it is connected to.
interface i2c_xfer_seq_if #(
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_addr;
  logic             req_rnw;
  logic [7:0]       req_reg;
  logic [LEN_W-1:0] req_len;

  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;

  logic [7:0]       rd_data;
  logic             rd_valid;

  logic             bc_start;
  logic             bc_stop;
  logic             bc_read;
  logic             bc_write;
  logic             bc_ack_in;
  logic [7:0]       bc_din;
  logic             bc_cmd_ack;
  logic             bc_ack_out;
  logic             bc_al;
  logic [7:0]       bc_dout;

  logic             busy;
  logic             done;
  logic             err_nack;
  logic             err_al;

  modport master (
    input  req_valid, req_addr, req_rnw, req_reg, req_len,
    input  wr_data, wr_valid,
    input  bc_cmd_ack, bc_ack_out, bc_al, bc_dout,
    output req_ready, wr_ready, rd_data, rd_valid,
    output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din,
    output busy, done, err_nack, err_al
  );

  modport slave (
    output req_valid, req_addr, req_rnw, req_reg, req_len,
    output wr_data, wr_valid,
    output bc_cmd_ack, bc_ack_out, bc_al, bc_dout,
    input  req_ready, wr_ready, rd_data, rd_valid,
    input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din,
    input  busy, done, err_nack, err_al
  );
endinterface

// File: rtl/i2c_xfer_seq.sv
// I2C register read/write sequencer: expands one request into byte-controller commands.
// Latency: first command 2 cycles after acceptance; one idle cycle between commands.
// Backpressure: req_ready only in IDLE; wr_ready only in WWAIT; rd stream has none.
module i2c_xfer_seq #(
  parameter int LEN_W = 4
) (
  input logic            HCLK,
  input logic            HRESETn,
  i2c_xfer_seq_if.master bus
);
  import i2c_seq_pkg::*;

  state_t           state_q, state_d;
  logic [6:0]       addr_q;
  logic             rnw_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;
  logic [7:0]       din_q, din_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             nack_q, nack_d;
  logic             al_q, al_d;
  logic             ready_q;
  logic             accept;
  logic             issue;
  logic             last;

  // A command state drives its command once the previous command has been
  // cleared; an all-zero command register therefore means "not yet issued".
  assign issue = (cmd_q == '0);
  assign last  = (cnt_q == LEN_W'(1));

  // Next-state, command and status decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    din_d      = din_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    nack_d     = nack_q;
    al_d       = al_q;
    accept     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ready_q && bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = bus.req_len;
          al_d    = 1'b0;
          nack_d  = (bus.req_len == '0);
          state_d = (bus.req_len == '0) ? FIN : ADDR;
        end
      end
      ADDR: begin
        if (issue) begin
          cmd_d.start = 1'b1;
          cmd_d.write = 1'b1;
          din_d       = {addr_q, WR};
        end else if (bus.bc_cmd_ack) begin
          cmd_d = '0;
          if (bus.bc_ack_out) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            state_d = REG;
          end
        end
      end
      REG: begin
        if (issue) begin
          cmd_d.write = 1'b1;
          din_d       = reg_q;
        end else if (bus.bc_cmd_ack) begin
          cmd_d = '0;
          if (bus.bc_ack_out) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            state_d = (rnw_q == RD) ? RADDR : WWAIT;
          end
        end
      end
      WWAIT: begin
        if (bus.wr_valid) begin
          din_d   = bus.wr_data;
          state_d = WDATA;
        end
      end
      WDATA: begin
        if (issue) begin
          cmd_d.write = 1'b1;
          cmd_d.stop  = last;
        end else if (bus.bc_cmd_ack) begin
          cmd_d = '0;
          if (bus.bc_ack_out) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
            state_d = last ? FIN : WWAIT;
          end
        end
      end
      RADDR: begin
        if (issue) begin
          cmd_d.start = 1'b1;
          cmd_d.write = 1'b1;
          din_d       = {addr_q, RD};
        end else if (bus.bc_cmd_ack) begin
          cmd_d = '0;
          if (bus.bc_ack_out) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        // The master NACKs and stops on the final byte
        if (issue) begin
          cmd_d.read   = 1'b1;
          cmd_d.ack_in = last;
          cmd_d.stop   = last;
        end else if (bus.bc_cmd_ack) begin
          cmd_d      = '0;
          rd_valid_d = 1'b1;
          rd_data_d  = bus.bc_dout;
          if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
          if (last) state_d = FIN;
        end
      end
      STOP: begin
        if (issue) begin
          cmd_d.stop = 1'b1;
        end else if (bus.bc_cmd_ack) begin
          cmd_d   = '0;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Lost arbitration abandons the bus: no STOP, straight to completion
    if (bus.bc_al && state_q != IDLE && state_q != FIN) begin
      state_d    = FIN;
      cmd_d      = '0;
      rd_valid_d = 1'b0;
      al_d       = 1'b1;
    end
  end

  // Request field capture on acceptance
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      rnw_q  <= WR;
      reg_q  <= '0;
    end else if (accept) begin
      addr_q <= bus.req_addr;
      rnw_q  <= bus.req_rnw;
      reg_q  <= bus.req_reg;
    end
  end

  // State, counter, command and status registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      din_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      nack_q     <= 1'b0;
      al_q       <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      din_q      <= din_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      nack_q     <= nack_d;
      al_q       <= al_d;
      ready_q    <= (state_d == IDLE);
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.wr_ready  = (state_q == WWAIT);
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.bc_start  = cmd_q.start;
  assign bus.bc_stop   = cmd_q.stop;
  assign bus.bc_read   = cmd_q.read;
  assign bus.bc_write  = cmd_q.write;
  assign bus.bc_ack_in = cmd_q.ack_in;
  assign bus.bc_din    = din_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.err_nack  = nack_q;
  assign bus.err_al    = al_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: byte-controller responder, write-data source and
// read-data monitor around the DUT; each transfer is compared against a
// command/data list derived from the request and the injected bus events.
module tb_i2c_xfer_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  // Per-transfer stimulus and observations
  logic [7:0]  wr_bytes[16];
  logic [7:0]  slave_bytes[16];
  logic [7:0]  wr_q[$];
  logic [12:0] got_cmd[$];
  logic [12:0] exp_cmd[$];
  logic [7:0]  got_rd[$];
  logic [7:0]  exp_rd[$];
  logic        exp_nack, exp_al;
  int          cmd_idx, rd_idx, nack_at, al_at, wr_ready_seen;

  i2c_xfer_seq_if #(.LEN_W(4)) bus ();

  i2c_xfer_seq #(.LEN_W(4)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Command record: {start, stop, read, write, ack_in, din}; din only meaningful for writes
  function automatic logic [12:0] mk(input logic s, input logic st, input logic rd,
                                     input logic wr, input logic ai, input logic [7:0] d);
    return {s, st, rd, wr, ai, (wr ? d : 8'h00)};
  endfunction

  // Byte-controller responder: logs each new command, checks it is held, acks after 0-2 cycles
  initial begin : bc_model
    logic [4:0] cur, hc;
    logic [7:0] cd, hd;
    logic       pend, acked;
    int         wait_n, my_idx;
    bus.bc_cmd_ack = 1'b0; bus.bc_ack_out = 1'b0; bus.bc_al = 1'b0; bus.bc_dout = 8'h00;
    pend = 1'b0; acked = 1'b0; wait_n = 0; my_idx = 0; hc = '0; hd = '0;
    forever begin
      @(negedge clk);
      bus.bc_cmd_ack = 1'b0; bus.bc_ack_out = 1'b0; bus.bc_al = 1'b0;
      cur = {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in};
      cd  = bus.bc_din;
      if (!rst_n) begin
        pend = 1'b0; acked = 1'b0;
        continue;
      end
      if (acked) begin
        checks++;
        if (cur !== 5'b0) begin
          errors++;
          $display("FAIL cmd_clear got %b expected 00000", cur);
        end
        acked = 1'b0;
      end else if (pend) begin
        checks++;
        if (cur !== hc || cd !== hd) begin
          errors++;
          $display("FAIL cmd_hold got %b/%h expected %b/%h", cur, cd, hc, hd);
        end
      end else if (cur != 5'b0) begin
        pend   = 1'b1;
        hc     = cur;
        hd     = cd;
        my_idx = cmd_idx;
        cmd_idx++;
        got_cmd.push_back({cur, (cur[1] ? cd : 8'h00)});
        wait_n = $urandom_range(0, 2);
      end
      if (pend) begin
        if (wait_n == 0) begin
          pend  = 1'b0;
          acked = 1'b1;
          if (my_idx == al_at) begin
            bus.bc_al = 1'b1;
          end else begin
            bus.bc_cmd_ack = 1'b1;
            bus.bc_ack_out = (my_idx == nack_at);
            if (hc[2] && rd_idx < 16) begin
              bus.bc_dout = slave_bytes[rd_idx];
              rd_idx++;
            end
          end
        end else begin
          wait_n--;
        end
      end
    end
  end

  // Write-data source with random valid gaps
  initial begin : wr_drv
    logic hs;
    hs = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs = 1'b0; bus.wr_valid = 1'b0;
        continue;
      end
      if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
      if (bus.wr_ready) wr_ready_seen++;
      if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wr_q[0];
      end else begin
        bus.wr_valid = 1'b0;
      end
      hs = bus.wr_valid && bus.wr_ready;
    end
  end

  // Read-data monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.rd_valid) got_rd.push_back(bus.rd_data);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 16; i++) begin
      wr_bytes[i]    = 8'($urandom);
      slave_bytes[i] = 8'($urandom);
    end
  endtask

  // Expected bus command list, read data and status from the request and injected events
  task automatic build_model(input logic [6:0] a, input logic rnw, input logic [7:0] r,
                             input int len, input int nk, input int al);
    logic [12:0] full[$];
    int ri;
    exp_cmd.delete(); exp_rd.delete();
    exp_nack = (len == 0);
    exp_al   = 1'b0;
    if (len == 0) return;
    full.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {a, 1'b0}));
    full.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, r));
    if (!rnw) begin
      for (int i = 0; i < len; i++)
        full.push_back(mk(1'b0, i == len - 1, 1'b0, 1'b1, 1'b0, wr_bytes[i]));
    end else begin
      full.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {a, 1'b1}));
      for (int i = 0; i < len; i++)
        full.push_back(mk(1'b0, i == len - 1, 1'b1, 1'b0, i == len - 1, 8'h00));
    end
    ri = 0;
    for (int k = 0; k < full.size(); k++) begin
      exp_cmd.push_back(full[k]);
      if (k == al) begin
        exp_al = 1'b1;
        break;
      end
      if (k == nk && full[k][9]) begin
        exp_nack = 1'b1;
        exp_cmd.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        break;
      end
      if (full[k][10]) begin
        exp_rd.push_back(slave_bytes[ri]);
        ri++;
      end
    end
  endtask

  // Arms the responder, builds the expectation and hands the request over
  task automatic start_xfer(input logic [6:0] a, input logic rnw, input logic [7:0] r,
                            input int len, input int nk, input int al);
    int n;
    got_cmd.delete(); got_rd.delete();
    cmd_idx = 0; rd_idx = 0; nack_at = nk; al_at = al; wr_ready_seen = 0;
    wr_q.delete();
    if (!rnw) for (int i = 0; i < len; i++) wr_q.push_back(wr_bytes[i]);
    build_model(a, rnw, r, len, nk, al);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_rnw   = rnw;
    bus.req_reg   = r;
    bus.req_len   = 4'(len);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept got %b expected 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_xfer(input string name, output int cyc);
    int n, m;
    n = 0;
    while (!bus.done && n < 800) begin
      @(negedge clk);
      n++;
    end
    cyc = n + 1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout got %b expected 1", name, bus.done);
      do_reset();
      return;
    end
    checks++;
    if (bus.err_nack !== exp_nack) begin
      errors++;
      $display("FAIL %s err_nack got %b expected %b", name, bus.err_nack, exp_nack);
    end
    checks++;
    if (bus.err_al !== exp_al) begin
      errors++;
      $display("FAIL %s err_al got %b expected %b", name, bus.err_al, exp_al);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse got %b expected 0", name, bus.done);
    end
    checks++;
    if (got_cmd.size() != exp_cmd.size()) begin
      errors++;
      $display("FAIL %s cmd_count got %0d expected %0d", name, got_cmd.size(), exp_cmd.size());
    end
    m = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (got_cmd[i] !== exp_cmd[i]) begin
        errors++;
        $display("FAIL %s cmd[%0d] got %h expected %h", name, i, got_cmd[i], exp_cmd[i]);
      end
    end
    checks++;
    if (got_rd.size() != exp_rd.size()) begin
      errors++;
      $display("FAIL %s rd_count got %0d expected %0d", name, got_rd.size(), exp_rd.size());
    end
    m = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (got_rd[i] !== exp_rd[i]) begin
        errors++;
        $display("FAIL %s rd[%0d] got %h expected %h", name, i, got_rd[i], exp_rd[i]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.err_nack, bus.err_al, bus.busy, bus.req_ready} !== {exp_nack, exp_al, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s idle_hold got %b expected %b", name,
               {bus.err_nack, bus.err_al, bus.busy, bus.req_ready}, {exp_nack, exp_al, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    #1 rst_n = 1'b0;
    #1;
    outs = {bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.bc_start, bus.bc_stop,
            bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din, bus.busy, bus.done,
            bus.err_nack, bus.err_al, 4'h0};
    checks++;
    if (outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 00000000", outs);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.busy, bus.done, bus.wr_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release got %b expected 1000",
               {bus.req_ready, bus.busy, bus.done, bus.wr_ready});
    end
  endtask

  task automatic test_write();
    int cyc;
    rand_bytes();
    wr_bytes[0] = 8'hA5;
    wr_bytes[1] = 8'h3C;
    start_xfer(7'h50, 1'b0, 8'h10, 2, -1, -1);
    finish_xfer("write", cyc);
  endtask

  task automatic test_read();
    int cyc;
    rand_bytes();
    slave_bytes[0] = 8'h11;
    slave_bytes[1] = 8'h22;
    slave_bytes[2] = 8'h33;
    start_xfer(7'h50, 1'b1, 8'h00, 3, -1, -1);
    finish_xfer("read", cyc);
  endtask

  task automatic test_addr_nack();
    int cyc;
    rand_bytes();
    start_xfer(7'h50, 1'b0, 8'h10, 2, 0, -1);
    finish_xfer("addr_nack", cyc);
    checks++;
    if (wr_ready_seen != 0) begin
      errors++;
      $display("FAIL addr_nack wr_ready_cycles got %0d expected 0", wr_ready_seen);
    end
  endtask

  task automatic test_al_reg();
    int cyc;
    rand_bytes();
    start_xfer(7'h50, 1'b0, 8'h10, 2, -1, 1);
    finish_xfer("al_reg", cyc);
  endtask

  task automatic test_len_zero();
    int cyc;
    rand_bytes();
    start_xfer(7'h50, 1'b0, 8'h10, 0, -1, -1);
    finish_xfer("len_zero", cyc);
    checks++;
    if (cyc > 2) begin
      errors++;
      $display("FAIL len_zero done_latency got %0d expected <=2", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    rand_bytes();
    start_xfer(7'h50, 1'b1, 8'h00, 3, -1, -1);
    n = 0;
    while (!bus.bc_read && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.bc_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid reach_rdata got %b expected 1", bus.bc_read);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.busy,
         bus.done, bus.req_ready, bus.rd_valid, bus.bc_din} !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid outputs got %h expected 00000",
               {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.busy,
                bus.done, bus.req_ready, bus.rd_valid, bus.bc_din});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_bytes();
    start_xfer(7'h2A, 1'b1, 8'h07, 3, -1, -1);
    finish_xfer("after_reset", cyc);
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic [7:0] r;
    logic       rnw;
    int         len, total, nk, al, sel, cyc;
    for (int t = 0; t < 25; t++) begin
      a     = 7'($urandom);
      r     = 8'($urandom);
      rnw   = 1'($urandom_range(0, 1));
      len   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      total = rnw ? len + 3 : len + 2;
      nk    = -1;
      al    = -1;
      sel   = $urandom_range(0, 5);
      if (sel == 0) nk = rnw ? int'($urandom_range(0, 2)) : int'($urandom_range(0, total - 1));
      else if (sel == 1) al = $urandom_range(0, total - 1);
      rand_bytes();
      start_xfer(a, rnw, r, len, nk, al);
      finish_xfer("random", cyc);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = 7'h00;
    bus.req_rnw   = 1'b0;
    bus.req_reg   = 8'h00;
    bus.req_len   = 4'h0;
    nack_at = -1; al_at = -1; cmd_idx = 0; rd_idx = 0; wr_ready_seen = 0;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_al_reg();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter LEN_W, default 4, sets the width of the byte-count field; the maximum transfer is 2^LEN_W-1 bytes.
REQ-002 HCLK  in  1  the single clock; all state SHALL be updated on its rising edge.
REQ-003 HRESETn  in  1  reset, asynchronous and active-low.
REQ-004 req_valid/req_ready  in/out  1/1  transaction request handshake; accepted on the cycle both are high.
REQ-005 req_addr  in  7  7-bit I2C slave address.
REQ-006 req_rnw  in  1  1 = register read, 0 = register write.
REQ-007 req_reg  in  8  slave register index, sent after the address byte.
REQ-008 req_len  in  LEN_W  data byte count; 0 is illegal.
REQ-009 wr_data/wr_valid/wr_ready  in/in/out  8/1/1  write-data stream; one byte is consumed per handshake.
REQ-010 rd_data/rd_valid  out/out  8/1  read-data stream; rd_valid is a 1-cycle pulse with no backpressure.
REQ-011 bc_start, bc_stop, bc_read, bc_write, bc_ack_in  out  1 each  byte-controller command levels.
REQ-012 bc_din  out  8  byte to transmit.
REQ-013 bc_cmd_ack, bc_ack_out, bc_al  in  1 each  byte-controller command done, slave ACK bit (1 = NACK), arbitration lost.
REQ-014 bc_dout  in  8  received byte.
REQ-015 busy  out  1  high from request acceptance until done.
REQ-016 done  out  1  1-cycle completion pulse.
REQ-017 err_nack  out  1  completion status bit, valid with done.
REQ-018 err_al  out  1  completion status bit, valid with done.

Function
REQ-019 The FSM SHALL have the states IDLE, ADDR, REG, WWAIT, WDATA, RADDR, RDATA, STOP, FIN.
REQ-020 In IDLE, req_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-021 A request with req_len=0 SHALL be accepted and go directly to FIN with err_nack=1; no bus activity SHALL occur.
REQ-022 On acceptance, the block SHALL latch addr/rnw/reg/len and enter ADDR.
REQ-023 In ADDR, the block SHALL drive bc_start=1, bc_write=1, bc_din={addr,0}.
REQ-024 In REG, the block SHALL drive bc_write=1, bc_din=reg.
REQ-025 Command outputs SHALL be registered and held until bc_cmd_ack; they SHALL be 0 on the cycle after bc_cmd_ack.
REQ-026 Each byte command SHALL advance the state only on bc_cmd_ack.
REQ-027 On bc_cmd_ack in ADDR, REG or WDATA with bc_ack_out=1, the block SHALL set err_nack and go to STOP.
REQ-028 After REG, a write SHALL go to WWAIT and a read SHALL go to RADDR.
REQ-029 In WWAIT, wr_ready SHALL be 1; on the wr handshake the byte SHALL be latched into bc_din and the FSM SHALL go to WDATA.
REQ-030 In WDATA, bc_write=1; on the last byte bc_stop=1 as well.
REQ-031 On bc_cmd_ack in WDATA, the remaining count SHALL decrement; the FSM SHALL return to WWAIT, or go to FIN if the count is 0.
REQ-032 In RADDR, the block SHALL drive bc_start=1, bc_write=1, bc_din={addr,1} (repeated start); on NACK it SHALL follow REQ-027.
REQ-033 In RDATA, bc_read=1; bc_ack_in=0 except on the last byte, where bc_ack_in=1 and bc_stop=1.
REQ-034 On each bc_cmd_ack in RDATA, rd_data=bc_dout and rd_valid=1 for one cycle.
REQ-035 After the last read byte, the FSM SHALL go to FIN.
REQ-036 In STOP, the block SHALL drive bc_stop=1 alone and go to FIN on bc_cmd_ack.
REQ-037 bc_al=1 in any non-IDLE state SHALL have priority over bc_cmd_ack: all commands clear next cycle, err_al=1, FSM goes to FIN, no STOP is issued.
REQ-038 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-039 err_nack and err_al SHALL hold until the next acceptance.
REQ-040 The byte counter SHALL be LEN_W bits wide; it SHALL load req_len and never wrap below 0.

Reset
REQ-041 HRESETn low SHALL force IDLE immediately, including mid-transfer, and clear all outputs.
REQ-042 All outputs SHALL be 0 in reset except req_ready, which SHALL be 1 after release.
REQ-043 Reset SHALL clear the latched request fields and the counter.

Structure
REQ-044 Package i2c_seq_pkg SHALL hold the state enum and the RNW bit constants (WR=0, RD=1).
REQ-045 The block SHALL be one flat module with no sub-module.

Verification
REQ-046 Write addr 0x50, reg 0x10, len 2, data 0xA5 then 0x3C -> bytes 0xA0, 0x10, 0xA5, 0x3C; stop on the last byte; done with no error.
REQ-047 Read addr 0x50, reg 0x00, len 3, slave returns 0x11, 0x22, 0x33 -> repeated start with 0xA1; three rd_valid pulses 0x11, 0x22, 0x33; ack_in=1 and stop on the third byte only.
REQ-048 Address NACK (ack_out=1 on 0xA0) -> STOP command alone, done, err_nack=1, wr_ready never asserted.
REQ-049 bc_al pulsed during REG -> commands 0 next cycle, done, err_al=1, no stop issued.
REQ-050 req_len=0 -> done within 2 cycles, err_nack=1, no bc_* command asserted.
REQ-051 HRESETn low during RDATA of a 3-byte read -> immediate IDLE, all bc_* 0; the next request proceeds normally.
